result_fixed_fifo: RTL

RESULT_FIXED_FIFO -- requirements
Module: result_fixed_fifo

---
 rtl/result_fixed_fifo.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/result_fixed_fifo.sv
// ============================================================================
// result_fixed_fifo: decimating float-to-fixed converter feeding a FWFT FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

`ifndef EXP_W
`define EXP_W 8
`endif
`ifndef MANT_W
`define MANT_W 23
`endif

module result_fixed_fifo #(
    parameter int EXP_W  = `EXP_W,
    parameter int MANT_W = `MANT_W,
    parameter int OSR    = 1,
    parameter int OUT_W  = 16,
    parameter int FRAC_W = 14,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [EXP_W+MANT_W:0]    in,
    input  logic                     in_valid,
    input  logic                     clear,
    output logic [OUT_W-1:0]         out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int c_bias     = (1 << (EXP_W - 1)) - 1;
    localparam int c_shiftOfs = FRAC_W - MANT_W - c_bias;
    localparam int c_wideW    = MANT_W + 1 + OUT_W;
    localparam int c_phW      = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int c_addrW    = $clog2(DEPTH);
    localparam int c_lvlW     = c_addrW + 1;

    logic [EXP_W-1:0]   w_exp;
    logic [MANT_W-1:0]  w_mant;
    logic               w_sign;
    int                 w_shift;
    logic [c_wideW-1:0] w_wide;
    logic [c_wideW-1:0] w_shifted;
    logic               w_sat;
    logic [OUT_W-2:0]   w_mag;
    logic               w_accept;
    logic [OUT_W-1:0]   w_s2Data;
    logic               w_rd;
    logic               w_full;
    logic               w_wrOk;
    logic               w_drop;

    logic [c_phW-1:0]   r_phase;
    logic               r_s1Valid;
    logic               r_s1Sign;
    logic               r_s1Sat;
    logic [OUT_W-2:0]   r_s1Mag;
    logic               r_s2Valid;
    logic [OUT_W-1:0]   r_s2Data;
    logic [OUT_W-1:0]   r_mem [DEPTH];
    logic [c_addrW-1:0] r_wrPtr;
    logic [c_addrW-1:0] r_rdPtr;
    logic [c_lvlW-1:0]  r_level;
    logic               r_overflow;
    logic [7:0]         r_dropCnt;

    assign w_sign = in[EXP_W+MANT_W];
    assign w_exp  = in[EXP_W+MANT_W-1:MANT_W];
    assign w_mant = in[MANT_W-1:0];

    // Scaled magnitude is 1.mant shifted by (exp - bias - MANT_W + FRAC_W); right shifts truncate toward zero.
    always_comb begin
        w_shift   = int'(w_exp) + c_shiftOfs;
        w_wide    = {{OUT_W{1'b0}}, 1'b1, w_mant};
        w_shifted = '0;
        w_sat     = 1'b0;
        if (w_exp == '0) begin
            w_shifted = '0;
        end else if (&w_exp) begin
            w_sat = 1'b1;
        end else if (w_shift >= OUT_W) begin
            w_sat = 1'b1;
        end else if (w_shift >= 0) begin
            w_shifted = w_wide << w_shift;
        end else begin
            w_shifted = w_wide >> (-w_shift);
        end
        w_sat = w_sat | (|w_shifted[c_wideW-1:OUT_W-1]);
        w_mag = w_shifted[OUT_W-2:0];
    end

    assign w_accept = in_valid && (r_phase == '0);

    always_comb begin
        w_s2Data = '0;
        if (r_s1Sat) begin
            w_s2Data = r_s1Sign ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            w_s2Data = r_s1Sign ? -{1'b0, r_s1Mag} : {1'b0, r_s1Mag};
        end
    end

    assign out_valid = (r_level != '0);
    assign w_full    = (r_level == c_lvlW'(DEPTH));
    assign w_rd      = out_valid && out_ready;
    assign w_wrOk    = r_s2Valid && (!w_full || w_rd);
    assign w_drop    = r_s2Valid && w_full && !w_rd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase    <= '0;
            r_s1Valid  <= 1'b0;
            r_s1Sign   <= 1'b0;
            r_s1Sat    <= 1'b0;
            r_s1Mag    <= '0;
            r_s2Valid  <= 1'b0;
            r_s2Data   <= '0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_dropCnt  <= '0;
        end else begin
            if (in_valid) begin
                r_phase <= (r_phase == c_phW'(OSR - 1)) ? '0 : r_phase + c_phW'(1);
            end
            r_s1Valid <= w_accept;
            r_s1Sign  <= w_sign;
            r_s1Sat   <= w_sat;
            r_s1Mag   <= w_mag;
            r_s2Valid <= r_s1Valid;
            r_s2Data  <= w_s2Data;

            if (w_wrOk) begin
                r_wrPtr <= r_wrPtr + c_addrW'(1);
            end
            if (w_rd) begin
                r_rdPtr <= r_rdPtr + c_addrW'(1);
            end
            case ({w_wrOk, w_rd})
                2'b10:   r_level <= r_level + c_lvlW'(1);
                2'b01:   r_level <= r_level - c_lvlW'(1);
                default: r_level <= r_level;
            endcase

            // A drop in the same cycle as clear wins and restarts the count at one.
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (clear) begin
                    r_dropCnt <= 8'd1;
                end else if (r_dropCnt != 8'hFF) begin
                    r_dropCnt <= r_dropCnt + 8'd1;
                end
            end else if (clear) begin
                r_overflow <= 1'b0;
                r_dropCnt  <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wrOk) begin
            r_mem[r_wrPtr] <= r_s2Data;
        end
    end

    assign out      = out_valid ? r_mem[r_rdPtr] : '0;
    assign level    = r_level;
    assign overflow = r_overflow;
    assign drop_cnt = r_dropCnt;

endmodule

`default_nettype wire
